instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/mips_pkg.sv | 17 +
 rtl/instr_fetch.sv | 98 +++++++++
 tb/tb_instr_fetch.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: reset/halt addresses and the fetch FSM state type.
package mips_pkg;

    localparam logic [31:0] RESET_VECTOR_C = 32'hBFC0_0000;
    localparam logic [31:0] HALT_ADDR_C    = 32'h0000_0000;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        PENDING = 2'd1,
        HALTED  = 2'd2
    } fetch_state_t;

    function automatic logic misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// MIPS-style instruction fetch stage: PC register, IF/ID register, implicit branch
// delay slot, stall-deferred redirects and halt on HALT_ADDR or misaligned target.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// RUN     | fetching; a redirect is taken directly when not stalled
// PENDING | a redirect arrived during a stall; target held until stall drops
// HALTED  | PC frozen at the accepted target; left only by reset
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_C,
    parameter logic [31:0] HALT_ADDR    = HALT_ADDR_C
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] instr_address,
    input  logic [31:0] instr_readdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus8_out,
    output logic        fetch_valid,
    output logic        active,
    output logic        fetch_error
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  pending_target;

    logic         accept;
    logic [31:0]  accept_target;
    logic [31:0]  next_pc;
    logic         halt_now;

    assign instr_address = pc;
    assign pc_plus8_out  = pc_out + 32'd8;

    always_comb begin
        accept        = 1'b0;
        accept_target = pending_target;
        case (state)
            RUN: begin
                accept        = !stall && redirect_valid;
                accept_target = redirect_target;
            end
            PENDING: begin
                accept        = !stall;
                accept_target = redirect_valid ? redirect_target : pending_target;
            end
            default: ;
        endcase
        next_pc  = accept ? accept_target : pc + 32'd4;
        halt_now = accept && ((accept_target == HALT_ADDR) || misaligned(accept_target));
    end

    // The delay slot is captured as valid on the accepting edge; active, fetch_valid
    // and fetch_error settle together on the first edge spent in HALTED.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= RUN;
            pc             <= RESET_VECTOR;
            pending_target <= 32'd0;
            instr_out      <= 32'd0;
            pc_out         <= 32'd0;
            fetch_valid    <= 1'b0;
            active         <= 1'b1;
            fetch_error    <= 1'b0;
        end else begin
            case (state)
                RUN, PENDING: begin
                    if (!stall) begin
                        instr_out   <= instr_readdata;
                        pc_out      <= pc;
                        fetch_valid <= 1'b1;
                        pc          <= next_pc;
                        state       <= halt_now ? HALTED : RUN;
                    end else if (redirect_valid) begin
                        pending_target <= redirect_target;
                        state          <= PENDING;
                    end
                end
                HALTED: begin
                    active      <= 1'b0;
                    fetch_valid <= 1'b0;
                    if (misaligned(pc)) begin
                        fetch_error <= 1'b1;
                    end
                end
                default: state <= HALTED;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: expected IF/ID addresses are queued as each
// cycle is driven and compared once the fetch stage presents them.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [31:0] pc_plus8_out;
    logic        fetch_valid;
    logic        active;
    logic        fetch_error;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction

    assign instr_readdata = mem(instr_address);

    instr_fetch dut (
        .clk             (clk),
        .reset           (reset),
        .instr_address   (instr_address),
        .instr_readdata  (instr_readdata),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .instr_out       (instr_out),
        .pc_out          (pc_out),
        .pc_plus8_out    (pc_plus8_out),
        .fetch_valid     (fetch_valid),
        .active          (active),
        .fetch_error     (fetch_error)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        logic [31:0] e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_pc"}, pc_out, e);
            chk({tag, "_instr"}, instr_out, mem(e));
            chk({tag, "_valid"}, {31'd0, fetch_valid}, 32'd1);
        end
    endtask

    task automatic fetch(input logic [31:0] exp_pc, input string tag);
        sb.push_back(exp_pc);
        cyc();
        pop_check(tag);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'd0;
        cyc();
        cyc();
        chk("rst_addr", instr_address, 32'hBFC0_0000);
        chk("rst_valid", {31'd0, fetch_valid}, 32'd0);
        chk("rst_pc_out", pc_out, 32'd0);
        chk("rst_instr_out", instr_out, 32'd0);
        chk("rst_active", {31'd0, active}, 32'd1);
        chk("rst_err", {31'd0, fetch_error}, 32'd0);

        reset = 1'b0;
        fetch(32'hBFC0_0000, "boot");
        chk("plus8", pc_plus8_out, 32'hBFC0_0008);
        fetch(32'hBFC0_0004, "seq1");

        redirect_valid = 1'b1; redirect_target = 32'h8000_0000;
        fetch(32'hBFC0_0008, "br_delay");
        redirect_valid = 1'b0;
        chk("br_addr", instr_address, 32'h8000_0000);
        fetch(32'h8000_0000, "br_tgt");
        fetch(32'h8000_0004, "br_seq");

        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h7FFE_0004;
        cyc();
        redirect_valid = 1'b0;
        chk("stall_pc_out", pc_out, 32'h8000_0004);
        chk("stall_addr", instr_address, 32'h8000_0008);
        cyc();
        cyc();
        chk("stall3_pc_out", pc_out, 32'h8000_0004);
        chk("stall3_instr", instr_out, mem(32'h8000_0004));
        chk("stall3_valid", {31'd0, fetch_valid}, 32'd1);
        stall = 1'b0;
        fetch(32'h8000_0008, "pend_delay");
        fetch(32'h7FFE_0004, "pend_tgt");

        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h1234_0000;
        cyc();
        redirect_target = 32'h2222_0000;
        cyc();
        stall = 1'b0; redirect_valid = 1'b0;
        fetch(32'h7FFE_0008, "ovr_delay");
        fetch(32'h2222_0000, "ovr_tgt");

        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
        fetch(32'h2222_0004, "wrap_delay");
        redirect_valid = 1'b0;
        fetch(32'hFFFF_FFFC, "wrap_top");
        chk("wrap_plus8", pc_plus8_out, 32'h0000_0004);
        fetch(32'h0000_0000, "wrap_zero");
        chk("wrap_active", {31'd0, active}, 32'd1);

        redirect_valid = 1'b1; redirect_target = 32'h0000_0000;
        fetch(32'h0000_0004, "halt_delay");
        redirect_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            stall = i[0];
            redirect_valid = i[1];
            redirect_target = 32'h1000 * (i + 1);
            cyc();
            chk("halt_active", {31'd0, active}, 32'd0);
            chk("halt_valid", {31'd0, fetch_valid}, 32'd0);
            chk("halt_addr", instr_address, 32'd0);
        end
        chk("halt_err", {31'd0, fetch_error}, 32'd0);

        stall = 1'b0; redirect_valid = 1'b0;
        reset = 1'b1;
        cyc();
        chk("rst2_addr", instr_address, 32'hBFC0_0000);
        chk("rst2_active", {31'd0, active}, 32'd1);
        reset = 1'b0;
        fetch(32'hBFC0_0000, "reboot");

        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h8000_0002;
        cyc();
        stall = 1'b0; redirect_valid = 1'b0;
        fetch(32'hBFC0_0004, "mis_delay");
        cyc();
        chk("mis_err", {31'd0, fetch_error}, 32'd1);
        chk("mis_active", {31'd0, active}, 32'd0);
        chk("mis_valid", {31'd0, fetch_valid}, 32'd0);
        chk("mis_addr", instr_address, 32'h8000_0002);

        reset = 1'b1;
        cyc();
        chk("rst3_err", {31'd0, fetch_error}, 32'd0);
        reset = 1'b0;
        fetch(32'hBFC0_0000, "boot3");
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h4000_0000;
        cyc();
        reset = 1'b1;
        cyc();
        chk("rst_pend_addr", instr_address, 32'hBFC0_0000);
        reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
        fetch(32'hBFC0_0000, "post_pend0");
        fetch(32'hBFC0_0004, "post_pend1");

        chk("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
